// File: rtl/button_event_decoder.sv
// Turns debounced button levels into single-cycle events and a sticky walk request for the controller FSM.
// Optional macro LONG_PRESS_EN: the reprogram button distinguishes short and long presses.
module button_event_decoder #(
   parameter int LONG_PRESS_CYCLES = 100_000_000,
   parameter int CNT_W             = 27
) (
   input  logic clk,
   input  logic sys_reset,
   input  logic reset_db_in,
   input  logic walkRequest_db_in,
   input  logic reprogram_db_in,
   input  logic walk_ack_in,
   output logic reset_pulse_out,
   output logic walk_pending_out,
   output logic reprogram_pulse_out,
   output logic reprogram_long_out
);

   // The counter must be able to reach LONG_PRESS_CYCLES-1 without wrapping.
   if ((LONG_PRESS_CYCLES < 2) || ((CNT_W < 31) && ((1 << CNT_W) <= LONG_PRESS_CYCLES))) begin : g_bad_cfg
      $error("button_event_decoder: LONG_PRESS_CYCLES must be >= 2 and fit in CNT_W bits");
   end

   logic reset_hist, walk_hist, reprogram_hist;
   logic reset_edge, walk_edge, reprogram_edge;

   assign reset_edge     = reset_db_in & ~reset_hist;
   assign walk_edge      = walkRequest_db_in & ~walk_hist;
   assign reprogram_edge = reprogram_db_in & ~reprogram_hist;

   // History tracks the inputs during reset too, so a button held through reset is not an edge.
   always_ff @(posedge clk) begin
      reset_hist     <= reset_db_in;
      walk_hist      <= walkRequest_db_in;
      reprogram_hist <= reprogram_db_in;
      if (!sys_reset) begin
         reset_pulse_out  <= 1'b0;
         walk_pending_out <= 1'b0;
      end else begin
         reset_pulse_out  <= reset_edge;
         walk_pending_out <= walk_edge | (walk_pending_out & ~walk_ack_in);
      end
   end

`ifdef LONG_PRESS_EN
   typedef enum logic [1:0] {R_IDLE, R_PRESS, R_LONG} rp_state_t;

   rp_state_t        state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             short_next, long_next;

   always_ff @(posedge clk) begin
      if (!sys_reset) begin
         state               <= R_IDLE;
         cnt                 <= '0;
         reprogram_pulse_out <= 1'b0;
         reprogram_long_out  <= 1'b0;
      end else begin
         state               <= state_next;
         cnt                 <= cnt_next;
         reprogram_pulse_out <= short_next;
         reprogram_long_out  <= long_next;
      end
   end

   // Release is tested before the long-press compare, so a release on the last count is still short.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      short_next = 1'b0;
      long_next  = 1'b0;
      case (state)
         R_IDLE: begin
            if (reprogram_edge) begin
               state_next = R_PRESS;
               cnt_next   = CNT_W'(1);
            end
         end
         R_PRESS: begin
            if (!reprogram_db_in) begin
               short_next = 1'b1;
               state_next = R_IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_W'(LONG_PRESS_CYCLES - 1)) begin
               long_next  = 1'b1;
               state_next = R_LONG;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         R_LONG: begin
            if (!reprogram_db_in) begin
               state_next = R_IDLE;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = R_IDLE;
            cnt_next   = '0;
         end
      endcase
   end
`else
   always_ff @(posedge clk) begin
      if (!sys_reset) begin
         reprogram_pulse_out <= 1'b0;
      end else begin
         reprogram_pulse_out <= reprogram_edge;
      end
   end

   assign reprogram_long_out = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios plus random button traffic against a press-duration reference model.
module tb_button_event_decoder;

   localparam int L  = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic sys_reset = 1'b0;
   logic reset_db_in = 1'b0;
   logic walkRequest_db_in = 1'b0;
   logic reprogram_db_in = 1'b0;
   logic walk_ack_in = 1'b0;
   logic reset_pulse_out, walk_pending_out, reprogram_pulse_out, reprogram_long_out;

   int n_cmp = 0;
   int n_bad = 0;
   int rst_pulses = 0;
   int short_cnt = 0;
   int long_cnt = 0;

   // Reference model: previous sampled levels, walk request flag, reprogram press length.
   bit m_prev_r, m_prev_w, m_prev_p;
   bit m_pend, m_act;
   int m_run;
   bit e_rp, e_sp, e_lp;

   button_event_decoder #(
      .LONG_PRESS_CYCLES(L),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .sys_reset(sys_reset),
      .reset_db_in(reset_db_in),
      .walkRequest_db_in(walkRequest_db_in),
      .reprogram_db_in(reprogram_db_in),
      .walk_ack_in(walk_ack_in),
      .reset_pulse_out(reset_pulse_out),
      .walk_pending_out(walk_pending_out),
      .reprogram_pulse_out(reprogram_pulse_out),
      .reprogram_long_out(reprogram_long_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp_v);
      end
   endtask

   task automatic model_edge();
      e_rp = 1'b0;
      e_sp = 1'b0;
      e_lp = 1'b0;
      if (!sys_reset) begin
         m_pend = 1'b0;
         m_act  = 1'b0;
         m_run  = 0;
      end else begin
         e_rp = reset_db_in && !m_prev_r;
         if (walkRequest_db_in && !m_prev_w) m_pend = 1'b1;
         else if (walk_ack_in) m_pend = 1'b0;
`ifdef LONG_PRESS_EN
         if (reprogram_db_in && !m_prev_p) begin
            m_act = 1'b1;
            m_run = 1;
         end else if (m_act && reprogram_db_in) begin
            m_run++;
            if (m_run == L) e_lp = 1'b1;
         end else if (m_act && !reprogram_db_in) begin
            e_sp  = (m_run < L);
            m_act = 1'b0;
         end
`else
         e_sp = reprogram_db_in && !m_prev_p;
`endif
      end
      m_prev_r = reset_db_in;
      m_prev_w = walkRequest_db_in;
      m_prev_p = reprogram_db_in;
   endtask

   task automatic cycle(input bit rs, input bit r, input bit w, input bit p, input bit a);
      sys_reset         = rs;
      reset_db_in       = r;
      walkRequest_db_in = w;
      reprogram_db_in   = p;
      walk_ack_in       = a;
      @(posedge clk);
      model_edge();
      #1;
      chk("reset_pulse", reset_pulse_out, e_rp);
      chk("walk_pending", walk_pending_out, m_pend);
      chk("reprog_short", reprogram_pulse_out, e_sp);
      chk("reprog_long", reprogram_long_out, e_lp);
      if (reset_pulse_out === 1'b1) rst_pulses++;
      if (reprogram_pulse_out === 1'b1) short_cnt++;
      if (reprogram_long_out === 1'b1) long_cnt++;
   endtask

   initial begin
      bit r, w, p, a, rs;

      // Walk held through reset must not register a request.
      repeat (3) cycle(0, 0, 1, 0, 0);
      chk("reset_state_pending", walk_pending_out, 1'b0);
      chk("reset_state_rpulse", reset_pulse_out, 1'b0);
      chk("reset_state_short", reprogram_pulse_out, 1'b0);
      chk("reset_state_long", reprogram_long_out, 1'b0);
      repeat (5) cycle(1, 0, 1, 0, 0);
      chk("held_walk_no_event", walk_pending_out, 1'b0);
      repeat (2) cycle(1, 0, 0, 0, 0);

      // Walk press, then ack.
      cycle(1, 0, 1, 0, 0);
      chk("walk_set", walk_pending_out, 1'b1);
      repeat (8) cycle(1, 0, 1, 0, 0);
      cycle(1, 0, 0, 0, 1);
      chk("walk_cleared", walk_pending_out, 1'b0);
      cycle(1, 0, 0, 0, 1);

      // New edge and ack together: new request wins.
      cycle(1, 0, 1, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 1, 0, 1);
      chk("edge_and_ack", walk_pending_out, 1'b1);
      cycle(1, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0);

      // Long reset button hold gives exactly one pulse.
      rst_pulses = 0;
      repeat (50) cycle(1, 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("one_reset_pulse", rst_pulses == 1, 1'b1);

      // Reprogram short press then long press.
      short_cnt = 0;
      long_cnt  = 0;
      repeat (3) cycle(1, 0, 0, 1, 0);
      repeat (5) cycle(1, 0, 0, 0, 0);
      chk("short_press_count", short_cnt == 1, 1'b1);
      chk("short_press_nolong", long_cnt == 0, 1'b1);
      short_cnt = 0;
      long_cnt  = 0;
      repeat (20) cycle(1, 0, 0, 1, 0);
      repeat (5) cycle(1, 0, 0, 0, 0);
`ifdef LONG_PRESS_EN
      chk("long_press_count", long_cnt == 1, 1'b1);
      chk("long_press_noshort", short_cnt == 0, 1'b1);
`else
      chk("press_pulse_count", short_cnt == 1, 1'b1);
      chk("press_nolong", long_cnt == 0, 1'b1);
`endif

      // Reset in the middle of a press, then a fresh press.
      short_cnt = 0;
      long_cnt  = 0;
      repeat (5) cycle(1, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(1, 0, 0, 1, 0);
      repeat (3) cycle(1, 0, 0, 0, 0);
`ifdef LONG_PRESS_EN
      chk("midpress_reset_silent", (short_cnt + long_cnt) == 0, 1'b1);
`else
      chk("midpress_reset_one", (short_cnt == 1) && (long_cnt == 0), 1'b1);
`endif
      short_cnt = 0;
      repeat (2) cycle(1, 0, 0, 1, 0);
      repeat (2) cycle(1, 0, 0, 0, 0);
      chk("press_after_reset", short_cnt == 1, 1'b1);

      // Random traffic with occasional resets.
      r = 0; w = 0; p = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(5) == 0) r = ~r;
         if ($urandom_range(5) == 0) w = ~w;
         if ($urandom_range(i % 2 == 0 ? 4 : 12) == 0) p = ~p;
         a  = ($urandom_range(7) == 0);
         rs = !($urandom_range(299) == 0);
         cycle(rs, r, w, p, a);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
